// File: rtl/store_align_unit.sv
`timescale 1ns/1ps
// Store path LSU -> data bus: lane alignment, byte enables, req/gnt/rvalid, zero-filled lanes; accept-to-done 3 cycles per beat at best.
// Backpressure: one store in flight, st_ready_o only in IDLE; request held stable until data_gnt_i.
// Build option STORE_MISALIGN_SPLIT_EN: split bus-word-crossing stores into two beats, else they end in error with no bus traffic.
module store_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  st_valid_i,
    output logic                  st_ready_o,
    input  logic [ADDR_W-1:0]     st_addr_i,
    input  logic [DATA_W-1:0]     st_wdata_i,
    input  logic [1:0]            st_size_i,
    output logic                  st_done_o,
    output logic                  st_err_o,
    output logic                  st_misaligned_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    input  logic                  data_err_i,
    output logic                  data_we_o,
    output logic [ADDR_W-1:0]     data_addr_o,
    output logic [DATA_W/8-1:0]   data_be_o,
    output logic [DATA_W-1:0]     data_wdata_o
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);

`ifdef STORE_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ1  = 3'd1,
        S_WAIT1 = 3'd2,
        S_REQ2  = 3'd3,
        S_WAIT2 = 3'd4,
        S_DONE  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ1  = 3'd1,
        S_WAIT1 = 3'd2,
        S_DONE  = 3'd5
    } state_t;
`endif

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_W-1:0]     r_addr;
    logic [2*NB-1:0]       r_be2;
    logic [2*DATA_W-1:0]   r_wd2;
    logic                  r_cross;
    logic                  r_err;

    logic [OW-1:0]         w_off;
    logic [3:0]            w_bytes;
    logic [4:0]            w_span;
    logic                  w_cross;
    logic                  w_legal;
    logic                  w_go_bus;
    logic                  w_accept;
    logic                  w_in_wait;
    logic [NB-1:0]         w_be_lo;
    logic [DATA_W-1:0]     w_wd_lo;
    logic [2*NB-1:0]       w_be2;
    logic [2*DATA_W-1:0]   w_wd2;

    assign w_off    = st_addr_i[OW-1:0];
    assign w_bytes  = 4'd1 << st_size_i;
    assign w_span   = 5'(w_off) + 5'(w_bytes);
    assign w_cross  = (w_span > 5'(NB));
    assign w_legal  = (st_size_i != 2'b11) || (DATA_W == 64);
    assign w_accept = st_valid_i && (r_state == S_IDLE);

`ifdef STORE_MISALIGN_SPLIT_EN
    assign w_go_bus  = w_legal;
    assign w_in_wait = (r_state == S_WAIT1) || (r_state == S_WAIT2);
`else
    // Without splitting, a crossing store cannot be expressed in one beat and is rejected.
    assign w_go_bus  = w_legal && !w_cross;
    assign w_in_wait = (r_state == S_WAIT1);
`endif

    // Keep only the bytes the size covers, LSB-justified, then move them onto the lanes.
    always_comb begin
        w_be_lo = '0;
        w_wd_lo = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(w_bytes)) begin
                w_be_lo[i]         = 1'b1;
                w_wd_lo[i*8 +: 8]  = st_wdata_i[i*8 +: 8];
            end
        end
    end

    assign w_be2 = {{NB{1'b0}}, w_be_lo} << w_off;
    assign w_wd2 = {{DATA_W{1'b0}}, w_wd_lo} << {w_off, 3'b000};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr  <= '0;
            r_be2   <= '0;
            r_wd2   <= '0;
            r_cross <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= {st_addr_i[ADDR_W-1:OW], {OW{1'b0}}};
            r_be2   <= w_be2;
            r_wd2   <= w_wd2;
            r_cross <= w_cross;
            r_err   <= !w_go_bus;
        end else if (w_in_wait && data_rvalid_i) begin
            r_err   <= data_err_i;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (st_valid_i) begin
                    w_next = w_go_bus ? S_REQ1 : S_DONE;
                end
            end
            S_REQ1: begin
                if (data_gnt_i) begin
                    w_next = S_WAIT1;
                end
            end
            S_WAIT1: begin
                // Responses seen while still requesting are ignored; only WAIT states consume rvalid.
                if (data_rvalid_i) begin
                    w_next = S_DONE;
`ifdef STORE_MISALIGN_SPLIT_EN
                    if (!data_err_i && r_cross) begin
                        w_next = S_REQ2;
                    end
`endif
                end
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            S_REQ2: begin
                if (data_gnt_i) begin
                    w_next = S_WAIT2;
                end
            end
            S_WAIT2: begin
                if (data_rvalid_i) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        st_ready_o      = 1'b0;
        st_done_o       = 1'b0;
        st_err_o        = 1'b0;
        st_misaligned_o = 1'b0;
        data_req_o      = 1'b0;
        data_we_o       = 1'b0;
        data_addr_o     = '0;
        data_be_o       = '0;
        data_wdata_o    = '0;
        case (r_state)
            S_IDLE: st_ready_o = 1'b1;
            S_REQ1: begin
                data_req_o   = 1'b1;
                data_we_o    = 1'b1;
                data_addr_o  = r_addr;
                data_be_o    = r_be2[NB-1:0];
                data_wdata_o = r_wd2[DATA_W-1:0];
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            S_REQ2: begin
                data_req_o   = 1'b1;
                data_we_o    = 1'b1;
                data_addr_o  = r_addr + ADDR_W'(NB);
                data_be_o    = r_be2[2*NB-1:NB];
                data_wdata_o = r_wd2[2*DATA_W-1:DATA_W];
            end
`endif
            S_DONE: begin
                st_done_o       = 1'b1;
                st_err_o        = r_err;
                st_misaligned_o = r_cross;
            end
            default: ;
        endcase
    end

`ifndef STORE_MISALIGN_SPLIT_EN
    // Second-beat halves exist only for the split build.
    logic w_unused_hi;
    assign w_unused_hi = ^{r_be2[2*NB-1:NB], r_wd2[2*DATA_W-1:DATA_W]};
`endif

endmodule
